// File: rtl/gps_ack_peak_detect.sv
// Acquisition peak detector: tracks the strongest and second-strongest non-adjacent
// correlator cells and issues a ratio-test verdict. Optional macro: GPS_ACK_ABS_THRESH_EN.
module gps_ack_peak_detect #(
  parameter logic [3:0]  RATIO_NUM  = 4'd3,
  parameter logic [3:0]  RATIO_DEN  = 4'd2,
  parameter logic [15:0] ABS_THRESH = 16'd64,
  parameter int          CODE_LEN   = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ack_start,
  input  logic               corr_complete,
  input  logic [9:0]         code_phase,
  input  logic signed [15:0] doppler_omega,
  input  logic [15:0]        integrator_0,
  input  logic               search_complete,
  input  logic               result_ready,
  output logic               result_valid,
  output logic               acq_detected,
  output logic [9:0]         peak_code_phase,
  output logic signed [15:0] peak_doppler,
  output logic [15:0]        peak_power,
  output logic [15:0]        second_power,
  output logic [15:0]        cell_count,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SEARCH, DECIDE, RESULT} state_t;

  localparam logic [9:0] WRAP_DIFF = 10'(CODE_LEN - 1);
`ifdef GPS_ACK_ABS_THRESH_EN
  localparam logic ABS_EN = 1'b1;
`else
  localparam logic ABS_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic               prev_cc_q, prev_cc_d;
  logic               prev_sc_q, prev_sc_d;
  logic [15:0]        peak_pwr_q, peak_pwr_d;
  logic [9:0]         peak_ph_q, peak_ph_d;
  logic signed [15:0] peak_dop_q, peak_dop_d;
  logic               peak_vld_q, peak_vld_d;
  logic [15:0]        second_q, second_d;
  logic [15:0]        count_q, count_d;
  logic               acq_q, acq_d;
  logic               rvld_q, rvld_d;
  logic               busy_q, busy_d;

  logic cell_ev, end_ev, adj_new;

  // Same Doppler bin and code phases within one chip, including the wrap at CODE_LEN-1 -> 0.
  function automatic logic adjacent(input logic [9:0] pa, input logic signed [15:0] da,
                                    input logic [9:0] pb, input logic signed [15:0] db);
    logic [9:0] diff;
    diff = (pa >= pb) ? (pa - pb) : (pb - pa);
    return (da == db) && ((diff <= 10'd1) || (diff == WRAP_DIFF));
  endfunction

  function automatic logic ratio_pass(input logic [15:0] pk, input logic [15:0] sc);
    logic [19:0] lhs, rhs;
    lhs = {4'd0, pk} * {16'd0, RATIO_DEN};
    rhs = {4'd0, sc} * {16'd0, RATIO_NUM};
    return lhs >= rhs;
  endfunction

  function automatic logic thresh_pass(input logic [15:0] pk);
    return !ABS_EN || (pk >= ABS_THRESH);
  endfunction

  always_comb begin
    state_d    = state_q;
    prev_cc_d  = corr_complete;
    prev_sc_d  = search_complete;
    peak_pwr_d = peak_pwr_q;
    peak_ph_d  = peak_ph_q;
    peak_dop_d = peak_dop_q;
    peak_vld_d = peak_vld_q;
    second_d   = second_q;
    count_d    = count_q;
    acq_d      = acq_q;
    rvld_d     = rvld_q;

    cell_ev = corr_complete & ~prev_cc_q;
    end_ev  = search_complete & ~prev_sc_q;
    adj_new = adjacent(peak_ph_q, peak_dop_q, code_phase, doppler_omega);

    if (ack_start) begin
      state_d    = SEARCH;
      peak_pwr_d = '0;
      peak_ph_d  = '0;
      peak_dop_d = '0;
      peak_vld_d = 1'b0;
      second_d   = '0;
      count_d    = '0;
      acq_d      = 1'b0;
      rvld_d     = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (cell_ev) begin
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            if (!peak_vld_q || (integrator_0 > peak_pwr_q)) begin
              // A displaced peak only survives as runner-up if it is not a sidelobe of the new one.
              if (peak_vld_q && !adj_new) second_d = peak_pwr_q;
              peak_pwr_d = integrator_0;
              peak_ph_d  = code_phase;
              peak_dop_d = doppler_omega;
              peak_vld_d = 1'b1;
            end else if (!adj_new && (integrator_0 > second_q)) begin
              second_d = integrator_0;
            end
          end
          if (end_ev) state_d = DECIDE;
        end
        DECIDE: begin
          acq_d   = peak_vld_q && ratio_pass(peak_pwr_q, second_q) && thresh_pass(peak_pwr_q);
          rvld_d  = 1'b1;
          state_d = RESULT;
        end
        RESULT: begin
          if (rvld_q && result_ready) begin
            rvld_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == SEARCH) || (state_d == DECIDE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_cc_q  <= 1'b0;
      prev_sc_q  <= 1'b0;
      peak_pwr_q <= '0;
      peak_ph_q  <= '0;
      peak_dop_q <= '0;
      peak_vld_q <= 1'b0;
      second_q   <= '0;
      count_q    <= '0;
      acq_q      <= 1'b0;
      rvld_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_cc_q  <= prev_cc_d;
      prev_sc_q  <= prev_sc_d;
      peak_pwr_q <= peak_pwr_d;
      peak_ph_q  <= peak_ph_d;
      peak_dop_q <= peak_dop_d;
      peak_vld_q <= peak_vld_d;
      second_q   <= second_d;
      count_q    <= count_d;
      acq_q      <= acq_d;
      rvld_q     <= rvld_d;
      busy_q     <= busy_d;
    end
  end

  assign result_valid    = rvld_q;
  assign acq_detected    = acq_q;
  assign peak_code_phase = peak_ph_q;
  assign peak_doppler    = peak_dop_q;
  assign peak_power      = peak_pwr_q;
  assign second_power    = second_q;
  assign cell_count      = count_q;
  assign busy            = busy_q;

endmodule

// File: doc/gps_ack_peak_detect.md
# gps_ack_peak_detect

Downstream consumer of the GPS acquisition correlator. Watches each completed code-phase/Doppler cell (`corr_complete`, `code_phase`, `doppler_omega`, `integrator_0`) and tracks the strongest and second-strongest non-adjacent cells. When `search_complete` rises it applies a peak-to-second ratio test. It then presents one acquisition verdict through a valid/ready handshake to the tracking-loop setup logic.

## Interface
- `RATIO_NUM`, 3 — ratio test numerator, 4-bit unsigned.
- `RATIO_DEN`, 2 — ratio test denominator, 4-bit unsigned, nonzero.
- `ABS_THRESH`, 16'd64 — minimum peak power; used only with the configuration macro.
- `CODE_LEN`, 1023 — number of code phases; phases are 0..CODE_LEN-1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ack_start`  in  1  new search starting; clears all tracked state.
- `corr_complete`  in  1  level from correlator; a cell is valid on its rising edge.
- `code_phase`  in  10  code phase of the cell.
- `doppler_omega`  in  16 signed  Doppler NCO word of the cell.
- `integrator_0`  in  16  incoherent power of the cell.
- `search_complete`  in  1  level; a rising edge ends the search.
- `result_ready`  in  1  consumer accepts the result.
- `result_valid`  out  1  verdict available.
- `acq_detected`  out  1  verdict: satellite acquired.
- `peak_code_phase`  out  10  code phase of the maximum cell.
- `peak_doppler`  out  16 signed  Doppler word of the maximum cell.
- `peak_power`  out  16  maximum power.
- `second_power`  out  16  second maximum power, excluding cells adjacent to the peak.
- `cell_count`  out  16  cells processed, saturating at 16'hFFFF.
- `busy`  out  1  high in SEARCH and DECIDE.

## Operation
- Edge detect: registered previous values of `corr_complete` and `search_complete`. A cell event is `corr_complete & ~prev`; an end event is `search_complete & ~prev`. Cell inputs are sampled in the same cycle as the cell event.
- States:
  - IDLE: waits for `ack_start`.
  - SEARCH: processes cell events until an end event.
  - DECIDE: one cycle.
  - RESULT: waits for `result_valid & result_ready`, then returns to IDLE.
- `ack_start` in any state clears the peak, second and count registers and enters SEARCH. It drops any pending result, so `result_valid` is 0 next cycle.
- Cell update (SEARCH only; events outside SEARCH are ignored). `cell_count` increments.
- Adjacency: adjacent(a,b) is true when Doppler words are equal and code phases differ by 0 or 1 modulo `CODE_LEN`, so phase 0 and phase 1022 are adjacent.
- If P > peak:
  - peak fields take the new cell.
  - second takes the old peak, unless the old peak is adjacent to the new cell; in that case second is unchanged.
- Else, if not adjacent to the peak and P > second, second takes P.
- Ties never replace; the first occurrence wins.
- The first cell after clear always becomes the peak, because peak clears to 0 and a valid flag is used. A zero-power first cell still sets the peak location.
- DECIDE: `acq_detected` = (peak × `RATIO_DEN`) >= (second × `RATIO_NUM`), computed in 20-bit unsigned. With zero cells processed, `acq_detected` = 0.
- A cell event and an end event in the same cycle: the cell is processed, then DECIDE uses the updated registers.

## Timing
- Reset values: all outputs 0, state IDLE, previous-value registers 0.
- Cell event at cycle N: registers updated at the end of N and visible at N+1.
- End event at cycle N: DECIDE at N+1, `result_valid` = 1 at N+2.
- `result_valid` and all result outputs stay stable until the handshake completes.
- `result_ready` high while `result_valid` is low has no effect.
- Handshake at cycle M: `result_valid` = 0 at M+1, state IDLE. Peak outputs keep their values until the next `ack_start`.
- `busy` is registered from the state.
- Reset mid-search discards everything and returns to IDLE.

## Configuration
- `GPS_ACK_ABS_THRESH_EN` defined: `acq_detected` additionally requires peak >= `ABS_THRESH`.
- Macro undefined: only the ratio test applies, and `ABS_THRESH` is unused.

## Test plan
- Reset, then idle: all outputs 0; cell events in IDLE leave `cell_count` = 0.
- `ack_start`, then cells (100, d0, 10), (101, d0, 50), (500, d0, 20), then an end event:
  - peak 50 @ 101.
  - second 20; the adjacent cell at 100 is excluded.
  - 50·2 >= 20·3, so `acq_detected` = 1.
  - `cell_count` = 3.
- Cells (0, d1, 40), (1022, d1, 45), (300, d2, 35):
  - peak 45 @ 1022 with wrap adjacency; second 35.
  - 90 < 105, so `acq_detected` = 0.
- `result_ready` held low 10 cycles: `result_valid` stays 1 with stable outputs. Raise `result_ready`: `result_valid` = 0 next cycle and state IDLE.
- Cell event coincident with end event, cell power 200: peak = 200 in the verdict. Separately, `ack_start` during RESULT clears `result_valid` and restarts.
- With `GPS_ACK_ABS_THRESH_EN`, `ABS_THRESH` = 64: peak 60 and second 10 give `acq_detected` = 0. Without the macro, the same stimulus gives `acq_detected` = 1.
